issue_bundler: RTL and testbench
================================

# issue_bundler

Dual-issue bundle former sitting between the fetch buffer and the opcode decode/control stage. It accepts one 16-bit instruction per handshake, classifies it by major opcode, and packs an ALU-class instruction followed in program order by a memory/branch/jump-class instruction into a two-slot bundle. Slot 1 carries the ALU instruction and slot 2 the mem/ctrl instruction. Any unfilled slot carries the NOP encoding (16'h0000).

## Interface
- HOLD_MAX, 4: max idle cycles an unpaired ALU instruction waits for a slot-2 partner (≥1)
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  in_instr valid
- in_instr  in  16  instruction; major opcode = in_instr[15:11]
- in_ready  out  1  combinational; = out_free && state≠HOLD_SOLO && !flush
- flush  in  1  force out any held ALU instruction as a solo bundle
- out_valid  out  1  bundle valid
- out_slot1  out  16  ALU slot (opcode1 = [15:9])
- out_slot2  out  16  mem/ctrl slot (opcode2 = [15:11])
- out_ready  in  1  decode stage accepts bundle

## Operation
- Classes, by [15:11]:
  - ALU: 00100 add, 00011 sub, 01000 cmp/shift
  - MEM: 10001 ld, 10000 st, 11100 jmp, 11010 br
  - NOP: 00000
  - INV: all other values
- out_free = !out_valid || out_ready. The output register loads only when out_free.
- Accept = in_valid && in_ready.
- Pairable(H,X): X is MEM. With the hazard check compiled in, the Configuration conditions must also not trigger.
- States: EMPTY, HOLD_ALU (hold register holds ALU instruction H), HOLD_SOLO (hold register holds MEM/INV instruction S).
- EMPTY, on accept of X:
  - ALU: H←X; →HOLD_ALU; hold_cnt←0
  - MEM: bundle {0,X}
  - INV: bundle {X,0}
  - NOP: consumed, no bundle
- HOLD_ALU, priority order:
  - flush && out_free: bundle {H,0}; →EMPTY
  - accept X, pairable: bundle {H,X}; →EMPTY
  - accept X, ALU: bundle {H,0}; H←X; hold_cnt←0
  - accept X, MEM not pairable or INV: bundle {H,0}; S←X; →HOLD_SOLO
  - accept NOP: consumed; H kept; hold_cnt unchanged
  - no accept, hold_cnt==HOLD_MAX, out_free: bundle {H,0}; →EMPTY
  - otherwise: hold_cnt increments, saturating at HOLD_MAX
- HOLD_SOLO: in_ready=0. When out_free, emit {0,S} for MEM or {S,0} for INV, then →EMPTY. flush has no extra effect.
- Flush in EMPTY: no effect except that in_ready=0 that cycle.
- Program order is preserved; no instruction is dropped except NOPs.

## Timing
- Reset values: out_valid=0, out_slot1=0, out_slot2=0, state=EMPTY, hold_cnt=0. in_ready=1 the cycle after reset (if flush=0).
- Reset mid-operation discards the held instruction and any pending bundle.
- Latency:
  - MEM/INV accepted in EMPTY: bundle valid the next cycle
  - paired bundle: valid the cycle after the MEM accept
  - lone ALU: valid HOLD_MAX+1 cycles after its accept, with no input and out_ready=1
- A bundle holds stable while out_valid && !out_ready. A new bundle may load in the same cycle the old one is taken.
- Sustained throughput is one instruction per cycle, except in HOLD_SOLO, which costs one bubble.

## Configuration
- PAIR_HAZARD_CHECK_EN defined: an ALU→MEM pair is refused (X is not pairable) if either condition holds:
  - H writes a register (add, sub, or 01000 with H[10:9]==01) and H[2:0] equals X[5:3] or X[8:6]
  - X is br (11010); every ALU instruction writes flags
- Undefined: every MEM following a held ALU pairs.

## Test plan
- Reset, then in 16'h2001 (add) followed next cycle by 16'h8800 (ld), out_ready=1 -> one bundle {16'h2001,16'h8800}; in_ready high throughout.
- Lone 16'h2001 with HOLD_MAX=4, no further input -> {16'h2001,0} appears after 5 cycles; out_valid high for 1 cycle.
- 16'h2001 then 16'hF800 (INV) -> {16'h2001,0} then {16'hF800,0}; in_ready low for exactly 1 cycle.
- With PAIR_HAZARD_CHECK_EN: 16'h2001 (dst r1) then 16'h8808 (src [5:3]=1) -> {16'h2001,0}, {0,16'h8808}. Without the macro -> single paired bundle.
- out_ready=0 for 3 cycles with a bundle pending -> out_slot1/2 stable, in_ready=0; resumes without loss.
- flush while holding 16'h1801 (sub) -> {16'h1801,0} next cycle. Reset asserted while holding -> no bundle, out_valid=0.

Source files
------------

// File: rtl/issue_bundler.sv
// Dual-issue bundle former: pairs an ALU instruction with a following mem/ctrl instruction.
// Optional macro PAIR_HAZARD_CHECK_EN refuses pairs with a register or flag dependency.
module issue_bundler #(
    parameter int unsigned HOLD_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [15:0] in_instr,
    output logic        in_ready,
    input  logic        flush,
    output logic        out_valid,
    output logic [15:0] out_slot1,
    output logic [15:0] out_slot2,
    input  logic        out_ready
);

    localparam int unsigned CNT_W = (HOLD_MAX < 1) ? 1 : $clog2(HOLD_MAX + 1);

    typedef enum logic [1:0] {EMPTY, HOLD_ALU, HOLD_SOLO} state_t;
    typedef enum logic [1:0] {CLS_NOP, CLS_ALU, CLS_MEM, CLS_INV} cls_t;

    // Major-opcode classification on bits [15:11].
    function automatic cls_t classify(input logic [4:0] op);
        cls_t c;
        case (op)
            5'b00100, 5'b00011, 5'b01000:           c = CLS_ALU;
            5'b10001, 5'b10000, 5'b11100, 5'b11010: c = CLS_MEM;
            5'b00000:                               c = CLS_NOP;
            default:                                c = CLS_INV;
        endcase
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [15:0]        hold_q, hold_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               out_free;
    logic               accept;
    cls_t               in_cls;
    cls_t               hold_cls;
    logic               pair_block;
    logic               cnt_at_max;
    logic               emit_c;
    logic [15:0]        slot1_c;
    logic [15:0]        slot2_c;

    assign out_free   = !out_valid || out_ready;
    assign in_ready   = out_free && (state_q != HOLD_SOLO) && !flush;
    assign accept     = in_valid && in_ready;
    assign in_cls     = classify(in_instr[15:11]);
    assign hold_cls   = classify(hold_q[15:11]);
    assign cnt_at_max = (cnt_q == CNT_W'(HOLD_MAX));

`ifdef PAIR_HAZARD_CHECK_EN
    // Held ALU result feeds an address/data source of the mem op, or a branch reads its flags.
    logic hold_writes_reg;
    assign hold_writes_reg = (hold_q[15:11] == 5'b00100) || (hold_q[15:11] == 5'b00011)
                          || ((hold_q[15:11] == 5'b01000) && (hold_q[10:9] == 2'b01));
    assign pair_block = (hold_writes_reg && ((hold_q[2:0] == in_instr[5:3])
                                          || (hold_q[2:0] == in_instr[8:6])))
                     || (in_instr[15:11] == 5'b11010);
`else
    assign pair_block = 1'b0;
`endif

    // Next-state and bundle formation.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        cnt_d   = cnt_q;
        emit_c  = 1'b0;
        slot1_c = 16'h0000;
        slot2_c = 16'h0000;
        case (state_q)
            EMPTY: begin
                if (accept) begin
                    case (in_cls)
                        CLS_ALU: begin
                            hold_d  = in_instr;
                            cnt_d   = '0;
                            state_d = HOLD_ALU;
                        end
                        CLS_MEM: begin
                            emit_c  = 1'b1;
                            slot2_c = in_instr;
                        end
                        CLS_INV: begin
                            emit_c  = 1'b1;
                            slot1_c = in_instr;
                        end
                        default: ;
                    endcase
                end
            end
            HOLD_ALU: begin
                if (flush && out_free) begin
                    emit_c  = 1'b1;
                    slot1_c = hold_q;
                    state_d = EMPTY;
                end else if (accept && in_cls == CLS_MEM && !pair_block) begin
                    emit_c  = 1'b1;
                    slot1_c = hold_q;
                    slot2_c = in_instr;
                    state_d = EMPTY;
                end else if (accept && in_cls == CLS_ALU) begin
                    emit_c  = 1'b1;
                    slot1_c = hold_q;
                    hold_d  = in_instr;
                    cnt_d   = '0;
                end else if (accept && in_cls != CLS_NOP) begin
                    emit_c  = 1'b1;
                    slot1_c = hold_q;
                    hold_d  = in_instr;
                    state_d = HOLD_SOLO;
                end else if (accept) begin
                    cnt_d = cnt_q;
                end else if (cnt_at_max && out_free) begin
                    emit_c  = 1'b1;
                    slot1_c = hold_q;
                    state_d = EMPTY;
                end else if (!cnt_at_max) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HOLD_SOLO: begin
                if (out_free) begin
                    emit_c  = 1'b1;
                    if (hold_cls == CLS_MEM) begin
                        slot2_c = hold_q;
                    end else begin
                        slot1_c = hold_q;
                    end
                    state_d = EMPTY;
                end
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= EMPTY;
            hold_q    <= 16'h0000;
            cnt_q     <= '0;
            out_valid <= 1'b0;
            out_slot1 <= 16'h0000;
            out_slot2 <= 16'h0000;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            cnt_q   <= cnt_d;
            if (out_free) begin
                out_valid <= emit_c;
                if (emit_c) begin
                    out_slot1 <= slot1_c;
                    out_slot2 <= slot2_c;
                end
            end
        end
    end

endmodule

// File: tb/tb_issue_bundler.sv
// Self-checking bench for issue_bundler: directed scenarios then randomized traffic
// compared cycle by cycle against a transaction-level reference model.
module tb_issue_bundler;

    localparam int unsigned HOLD_MAX = 4;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic [15:0] in_instr;
    logic        in_ready;
    logic        flush;
    logic        out_valid;
    logic [15:0] out_slot1;
    logic [15:0] out_slot2;
    logic        out_ready;

    int checks   = 0;
    int failures = 0;
    bit ready_known = 0;

    // Reference model state: at most one held instruction, plus the output register image.
    logic [15:0] held_q[$];
    bit          held_alu;
    int          age;
    bit          m_ov;
    logic [15:0] m_o1;
    logic [15:0] m_o2;

    issue_bundler #(.HOLD_MAX(HOLD_MAX)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_ready  (in_ready),
        .flush     (flush),
        .out_valid (out_valid),
        .out_slot1 (out_slot1),
        .out_slot2 (out_slot2),
        .out_ready (out_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 0 = NOP, 1 = ALU, 2 = MEM/ctrl, 3 = invalid
    function automatic int cls(input logic [15:0] i);
        logic [4:0] op;
        op = i[15:11];
        if (op == 5'b00100 || op == 5'b00011 || op == 5'b01000) return 1;
        if (op == 5'b10001 || op == 5'b10000 || op == 5'b11100 || op == 5'b11010) return 2;
        if (op == 5'b00000) return 0;
        return 3;
    endfunction

    function automatic bit pairable(input logic [15:0] h, input logic [15:0] x);
        if (cls(x) != 2) return 1'b0;
`ifdef PAIR_HAZARD_CHECK_EN
        begin
            bit wr;
            bit haz;
            wr  = (h[15:11] == 5'b00100) || (h[15:11] == 5'b00011)
               || (h[15:11] == 5'b01000 && h[10:9] == 2'b01);
            haz = (wr && (h[2:0] == x[5:3] || h[2:0] == x[8:6])) || (x[15:11] == 5'b11010);
            return !haz;
        end
`else
        return 1'b1;
`endif
    endfunction

    function automatic logic [15:0] rnd_instr();
        logic [4:0] op;
        case ($urandom_range(0, 9))
            0, 1:    op = 5'b00100;
            2:       op = 5'b00011;
            3:       op = 5'b01000;
            4:       op = 5'b10001;
            5:       op = 5'b10000;
            6:       op = 5'b11100;
            7:       op = 5'b11010;
            8:       op = 5'b00000;
            default: op = 5'b11111;
        endcase
        return {op, 11'($urandom_range(0, 2047))};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance the model by one clock given this cycle's inputs; returns the expected in_ready.
    task automatic model_step(input bit v, input logic [15:0] x, input bit fl, input bit ordy,
                              input bit rst, output bit exp_ready);
        bit free;
        bit acc;
        bit emit;
        logic [15:0] b1;
        logic [15:0] b2;
        logic [15:0] h;
        free      = !m_ov || ordy;
        exp_ready = free && !(held_q.size() != 0 && !held_alu) && !fl;
        if (rst) begin
            held_q.delete();
            held_alu = 1'b0;
            age  = 0;
            m_ov = 1'b0;
            m_o1 = 16'h0000;
            m_o2 = 16'h0000;
            return;
        end
        acc  = v && exp_ready;
        emit = 1'b0;
        b1   = 16'h0000;
        b2   = 16'h0000;
        if (held_q.size() == 0) begin
            if (acc) begin
                case (cls(x))
                    1: begin held_q.push_back(x); held_alu = 1'b1; age = 0; end
                    2: begin emit = 1'b1; b2 = x; end
                    3: begin emit = 1'b1; b1 = x; end
                    default: ;
                endcase
            end
        end else if (held_alu) begin
            h = held_q[0];
            if (fl && free) begin
                emit = 1'b1; b1 = h; held_q.delete();
            end else if (acc && pairable(h, x)) begin
                emit = 1'b1; b1 = h; b2 = x; held_q.delete();
            end else if (acc && cls(x) == 1) begin
                emit = 1'b1; b1 = h; held_q[0] = x; age = 0;
            end else if (acc && cls(x) != 0) begin
                emit = 1'b1; b1 = h; held_q[0] = x; held_alu = 1'b0;
            end else if (acc) begin
                emit = 1'b0;
            end else if (age == int'(HOLD_MAX) && free) begin
                emit = 1'b1; b1 = h; held_q.delete();
            end else if (age < int'(HOLD_MAX)) begin
                age++;
            end
        end else if (free) begin
            h = held_q[0];
            emit = 1'b1;
            if (cls(h) == 2) b2 = h;
            else b1 = h;
            held_q.delete();
        end
        if (free) begin
            m_ov = emit;
            if (emit) begin
                m_o1 = b1;
                m_o2 = b2;
            end
        end
    endtask

    task automatic cycle(input bit v, input logic [15:0] x, input bit fl, input bit ordy,
                         input bit rst);
        bit exp_ready;
        @(negedge clk);
        in_valid  = v;
        in_instr  = x;
        flush     = fl;
        out_ready = ordy;
        reset     = rst;
        #1;
        model_step(v, x, fl, ordy, rst, exp_ready);
        if (ready_known) check("in_ready", 16'(in_ready), 16'(exp_ready));
        @(posedge clk);
        #1;
        check("out_valid", 16'(out_valid), 16'(m_ov));
        check("out_slot1", out_slot1, m_o1);
        check("out_slot2", out_slot2, m_o2);
        if (rst) ready_known = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        in_valid  = 1'b0;
        in_instr  = 16'h0000;
        flush     = 1'b0;
        out_ready = 1'b1;
        reset     = 1'b1;

        // Reset state
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        check("rst_valid", 16'(out_valid), 16'h0000);
        check("rst_slot1", out_slot1, 16'h0000);
        idle(1);

        // add then ld pair into one bundle
        cycle(1'b1, 16'h2001, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'h8800, 1'b0, 1'b1, 1'b0);
        check("pair_valid", 16'(out_valid), 16'h0001);
        check("pair_slot1", out_slot1, 16'h2001);
        check("pair_slot2", out_slot2, 16'h8800);
        idle(2);

        // Lone ALU times out after HOLD_MAX+1 cycles
        cycle(1'b1, 16'h2001, 1'b0, 1'b1, 1'b0);
        idle(4);
        check("lone_early", 16'(out_valid), 16'h0000);
        idle(1);
        check("lone_valid", 16'(out_valid), 16'h0001);
        check("lone_slot1", out_slot1, 16'h2001);
        idle(2);

        // ALU followed by invalid opcode: two bundles, one bubble
        cycle(1'b1, 16'h2001, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'hF800, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b0);
        check("inv_slot1", out_slot1, 16'hF800);
        idle(2);

        // Register dependency pair (split only with the hazard check)
        cycle(1'b1, 16'h2001, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'h8808, 1'b0, 1'b1, 1'b0);
        idle(3);

        // Backpressure holds the bundle stable
        cycle(1'b1, 16'h2001, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'h8800, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b1, 16'h2002, 1'b0, 1'b0, 1'b0);
        check("stall_slot2", out_slot2, 16'h8800);
        cycle(1'b1, 16'h2002, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        idle(2);

        // Flush while holding, then reset while holding
        cycle(1'b1, 16'h1801, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("flush_slot1", out_slot1, 16'h1801);
        idle(1);
        cycle(1'b1, 16'h2001, 1'b0, 1'b1, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        idle(7);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cycle(bit'($urandom_range(0, 3) != 0), rnd_instr(),
                  bit'($urandom_range(0, 9) == 0), bit'($urandom_range(0, 9) < 7),
                  bit'($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
